// File: rtl/core_pipe_ctrl.sv
// Hazard/stall scheduler for the in-order RV64IM pipeline: load-use bubbles, redirect flushes, M-op EX hold.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module core_pipe_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int RFIDX_W = 5,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RFIDX_W-1:0] id_rs1_idx_i,
  input  logic [RFIDX_W-1:0] id_rs2_idx_i,
  input  logic               id_rs1_ren_i,
  input  logic               id_rs2_ren_i,
  input  logic [RFIDX_W-1:0] ex_rsd_idx_i,
  input  logic               ex_mem_read_i,
  input  logic               ex_is_muldiv_i,
  input  logic               ex_is_div_i,
  input  logic               redirect_i,
  output logic               pc_wen_o,
  output logic               if_id_wen_o,
  output logic               if_id_flush_o,
  output logic               id_ex_wen_o,
  output logic               id_ex_flush_o,
  output logic               md_start_o,
  output logic               md_busy_o,
  output logic               md_done_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        lu_stall_cnt_o,
  output logic [31:0]        md_stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic pc_wen;
    logic if_id_wen;
    logic if_id_flush;
    logic id_ex_wen;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // The start cycle and the done cycle are both part of the L-cycle occupancy.
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             md_stall, md_start, md_busy, md_done;
  logic             lu;
  pipe_ctrl_t       ctrl;

  assign lu = ex_mem_read_i && (ex_rsd_idx_i != '0) &&
              ((id_rs1_ren_i && (id_rs1_idx_i == ex_rsd_idx_i)) ||
               (id_rs2_ren_i && (id_rs2_idx_i == ex_rsd_idx_i)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_stall  = 1'b0;
    md_start  = 1'b0;
    md_busy   = 1'b0;
    md_done   = 1'b0;
    case (state)
      IDLE: begin
        if (ex_is_muldiv_i) begin
          md_start  = 1'b1;
          md_stall  = 1'b1;
          cnt_nxt   = ex_is_div_i ? DIV_INIT : MUL_INIT;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        md_busy = 1'b1;
        if (cnt != '0) begin
          md_stall = 1'b1;
          cnt_nxt  = cnt - 1'b1;
        end else begin
          md_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A redirect while an M-op holds EX is dropped: the stall branch wins outright.
  always_comb begin
    ctrl = '{pc_wen: 1'b1, if_id_wen: 1'b1, if_id_flush: 1'b0,
             id_ex_wen: 1'b1, id_ex_flush: 1'b0};
    if (md_stall) begin
      ctrl.pc_wen    = 1'b0;
      ctrl.if_id_wen = 1'b0;
      ctrl.id_ex_wen = 1'b0;
    end else if (redirect_i) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (lu) begin
      ctrl.pc_wen      = 1'b0;
      ctrl.if_id_wen   = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  // Outputs are pinned to their idle values while reset is held.
  always_comb begin
    pc_wen_o      = 1'b1;
    if_id_wen_o   = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_wen_o   = 1'b1;
    id_ex_flush_o = 1'b0;
    md_start_o    = 1'b0;
    md_busy_o     = 1'b0;
    md_done_o     = 1'b0;
    if (rst_n) begin
      pc_wen_o      = ctrl.pc_wen;
      if_id_wen_o   = ctrl.if_id_wen;
      if_id_flush_o = ctrl.if_id_flush;
      id_ex_wen_o   = ctrl.id_ex_wen;
      id_ex_flush_o = ctrl.id_ex_flush;
      md_start_o    = md_start;
      md_busy_o     = md_busy;
      md_done_o     = md_done;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic lu_win, flush_win;
  assign lu_win    = !md_stall && !redirect_i && lu;
  assign flush_win = !md_stall && redirect_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt_o <= '0;
      md_stall_cnt_o <= '0;
      flush_cnt_o    <= '0;
    end else begin
      if (lu_win && (lu_stall_cnt_o != '1))    lu_stall_cnt_o <= lu_stall_cnt_o + 32'd1;
      if (md_stall && (md_stall_cnt_o != '1))  md_stall_cnt_o <= md_stall_cnt_o + 32'd1;
      if (flush_win && (flush_cnt_o != '1))    flush_cnt_o    <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule
